// File: rtl/idecode_fwd_pkg.sv
// Shared instruction-format constants, decode enums and decode helpers for the
// decode/forwarding stage.
//
// Instruction layout (32 bits):
//   [31:27] opc  [26] immf  [25:23] rd  [22:20] rs  [19:16] cc  [15:0] imm
package idecode_fwd_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned W_OPC  = 5;
  localparam int unsigned W_DOPC = 4;
  localparam int unsigned W_CC   = 4;
  localparam int unsigned W_IMM  = 16;
  localparam int unsigned W_REG  = 3;

  localparam int unsigned OPC_MSB  = 31;
  localparam int unsigned OPC_LSB  = 27;
  localparam int unsigned IMMF_BIT = 26;
  localparam int unsigned RD_MSB   = 25;
  localparam int unsigned RD_LSB   = 23;
  localparam int unsigned RS_MSB   = 22;
  localparam int unsigned RS_LSB   = 20;
  localparam int unsigned CC_MSB   = 19;
  localparam int unsigned CC_LSB   = 16;
  localparam int unsigned IMM_MSB  = 15;
  localparam int unsigned IMM_LSB  = 0;

  typedef enum logic [W_OPC-1:0] {
    OP_NOP = 5'd0,
    OP_ADD = 5'd1,
    OP_SUB = 5'd2,
    OP_AND = 5'd3,
    OP_OR  = 5'd4,
    OP_XOR = 5'd5,
    OP_SHL = 5'd6,
    OP_SHR = 5'd7,
    OP_LD  = 5'd8,
    OP_ST  = 5'd9,
    OP_BR  = 5'd10,
    OP_LUI = 5'd11,
    OP_MOV = 5'd12,
    OP_CMP = 5'd13
  } opc_e;

  typedef enum logic [W_DOPC-1:0] {
    DOPC_NOP = 4'd0,
    DOPC_ADD = 4'd1,
    DOPC_SUB = 4'd2,
    DOPC_AND = 4'd3,
    DOPC_OR  = 4'd4,
    DOPC_XOR = 4'd5,
    DOPC_SHL = 4'd6,
    DOPC_SHR = 4'd7,
    DOPC_LD  = 4'd8,
    DOPC_ST  = 4'd9,
    DOPC_BR  = 4'd10,
    DOPC_MOV = 4'd11
  } dopc_e;

  typedef struct packed {
    logic [W_OPC-1:0] opc;
    logic             immf;
    logic [W_REG-1:0] rd;
    logic [W_REG-1:0] rs;
    logic [W_CC-1:0]  cc;
    logic [W_IMM-1:0] imm;
  } inst_fields_t;

  // Split a raw instruction word into its fields.
  function automatic inst_fields_t extract_fields(input logic [INST_W-1:0] inst);
    inst_fields_t f;
    f.opc  = inst[OPC_MSB:OPC_LSB];
    f.immf = inst[IMMF_BIT];
    f.rd   = inst[RD_MSB:RD_LSB];
    f.rs   = inst[RS_MSB:RS_LSB];
    f.cc   = inst[CC_MSB:CC_LSB];
    f.imm  = inst[IMM_MSB:IMM_LSB];
    return f;
  endfunction

  // Map the architectural opcode onto the EX operation code.
  // CMP executes as a subtract with no writeback; LUI executes as a move.
  function automatic logic [W_DOPC-1:0] decode_ope(input logic [W_OPC-1:0] opc);
    logic [W_DOPC-1:0] d;
    d = DOPC_NOP;
    case (opc)
      OP_ADD:         d = DOPC_ADD;
      OP_SUB, OP_CMP: d = DOPC_SUB;
      OP_AND:         d = DOPC_AND;
      OP_OR:          d = DOPC_OR;
      OP_XOR:         d = DOPC_XOR;
      OP_SHL:         d = DOPC_SHL;
      OP_SHR:         d = DOPC_SHR;
      OP_LD:          d = DOPC_LD;
      OP_ST:          d = DOPC_ST;
      OP_BR:          d = DOPC_BR;
      OP_LUI, OP_MOV: d = DOPC_MOV;
      default:        d = DOPC_NOP;
    endcase
    return d;
  endfunction

  // Logical ops zero-extend, LUI places imm in the upper half, others sign-extend.
  function automatic logic [INST_W-1:0] expand_imm(input logic [W_OPC-1:0] opc,
                                                   input logic [W_IMM-1:0] imm);
    logic [INST_W-1:0] r;
    r = {{(INST_W-W_IMM){imm[W_IMM-1]}}, imm};
    case (opc)
      OP_AND, OP_OR, OP_XOR: r = {{(INST_W-W_IMM){1'b0}}, imm};
      OP_LUI:                r = {imm, {(INST_W-W_IMM){1'b0}}};
      default:               r = {{(INST_W-W_IMM){imm[W_IMM-1]}}, imm};
    endcase
    return r;
  endfunction

  // Opcodes that write a result back to rd.
  function automatic logic wb_required(input logic [W_OPC-1:0] opc);
    logic w;
    w = 1'b0;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_LD, OP_LUI, OP_MOV: w = 1'b1;
      default:                               w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/idecode_fwd_if.sv
// Decode-stage bus bundle: IF handshake, register-file read/reserve ports,
// forwarding result buses and the registered EX payload.
// slave  : the decode stage itself.
// master : the surrounding pipeline (IF, RF, EX, result buses).
interface idecode_fwd_if #(
  parameter int unsigned WORD  = 32,
  parameter int unsigned ADDR  = 16,
  parameter int unsigned W_RD  = 3,
  parameter int unsigned N_FWD = 2
);
  import idecode_fwd_pkg::*;

  // IF side
  logic                    v_i;
  logic [WORD-1:0]         inst_i;
  logic [ADDR-1:0]         origaddr_i;
  logic                    stall_o;
  logic                    flush_i;
  // register file
  logic [W_RD-1:0]         rd_name_o;
  logic [W_RD-1:0]         rs_name_o;
  logic [WORD-1:0]         rd_data_i;
  logic [WORD-1:0]         rs_data_i;
  logic                    rd_reserved_i;
  logic                    rs_reserved_i;
  logic                    rd_reserve_o;
  // result buses, index 0 youngest
  logic [N_FWD-1:0]        fwd_v_i;
  logic [N_FWD*W_RD-1:0]   fwd_name_i;
  logic [N_FWD*WORD-1:0]   fwd_data_i;
  // EX side
  logic                    v_o;
  logic [WORD-1:0]         src_o;
  logic [WORD-1:0]         dest_o;
  logic                    wb_o;
  logic [W_RD-1:0]         wb_rd_name_o;
  logic [W_DOPC-1:0]       dopc_o;
  logic [W_OPC-1:0]        opc_o;
  logic [ADDR-1:0]         origaddr_o;
  logic [W_CC-1:0]         cc_o;
  logic [ADDR-1:0]         dm_addr_o;
  logic                    stall_i;

  modport slave (
    input  v_i, inst_i, origaddr_i, flush_i,
    input  rd_data_i, rs_data_i, rd_reserved_i, rs_reserved_i,
    input  fwd_v_i, fwd_name_i, fwd_data_i, stall_i,
    output stall_o, rd_name_o, rs_name_o, rd_reserve_o,
    output v_o, src_o, dest_o, wb_o, wb_rd_name_o, dopc_o, opc_o,
    output origaddr_o, cc_o, dm_addr_o
  );

  modport master (
    output v_i, inst_i, origaddr_i, flush_i,
    output rd_data_i, rs_data_i, rd_reserved_i, rs_reserved_i,
    output fwd_v_i, fwd_name_i, fwd_data_i, stall_i,
    input  stall_o, rd_name_o, rs_name_o, rd_reserve_o,
    input  v_o, src_o, dest_o, wb_o, wb_rd_name_o, dopc_o, opc_o,
    input  origaddr_o, cc_o, dm_addr_o
  );

endinterface

// File: rtl/idecode_fwd_sel.sv
// Operand resolution for one register name.
// Ports: name / rf_data / reserved from the register file, the forwarding
// result buses, and the resolved value data_c plus hazard_c (combinational).
module idecode_fwd_sel #(
  parameter int unsigned WORD  = 32,
  parameter int unsigned W_RD  = 3,
  parameter int unsigned N_FWD = 2
) (
  input  logic [W_RD-1:0]       name,
  input  logic [WORD-1:0]       rf_data,
  input  logic                  reserved,
  input  logic [N_FWD-1:0]      fwd_v,
  input  logic [N_FWD*W_RD-1:0] fwd_name,
  input  logic [N_FWD*WORD-1:0] fwd_data,
  output logic [WORD-1:0]       data_c,
  output logic                  hazard_c
);

  logic            hit;
  logic [WORD-1:0] fwd_val;

  // Scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    fwd_val = '0;
    for (int k = int'(N_FWD) - 1; k >= 0; k--) begin
      if (fwd_v[k] && (fwd_name[k*W_RD +: W_RD] == name)) begin
        hit     = 1'b1;
        fwd_val = fwd_data[k*WORD +: WORD];
      end
    end
  end

  // Unreserved registers come straight from the register file.
  always_comb begin
    data_c   = reserved ? fwd_val : rf_data;
    hazard_c = reserved & ~hit;
  end

endmodule

// File: rtl/idecode_fwd.sv
// Instruction decode with operand forwarding.
// Ports: clk, rst (async, active low), bus (decode side of idecode_fwd_if:
// IF handshake, RF read/reserve, result buses, registered EX payload) and
// hazard_cnt_o (saturating count of hazard-stall cycles).
// stall_o, rd_reserve_o and the rd/rs names are combinational; the EX payload
// is registered with one cycle of latency.
module idecode_fwd
  import idecode_fwd_pkg::*;
#(
  parameter int unsigned WORD  = 32,
  parameter int unsigned ADDR  = 16,
  parameter int unsigned W_RD  = 3,
  parameter int unsigned N_FWD = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  idecode_fwd_if.slave     bus,
  output logic [CNT_W-1:0] hazard_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  inst_fields_t      f_c;
  logic [WORD-1:0]   rd_val_c;
  logic [WORD-1:0]   rs_val_c;
  logic              rd_hz_c;
  logic              rs_hz_c;
  logic              hazard_c;
  logic              v_c;
  logic              wb_c;
  logic [WORD-1:0]   imm_sext_c;
  logic [WORD-1:0]   src_c;
  logic [ADDR-1:0]   dm_addr_c;

  logic              v_r;
  logic [WORD-1:0]   src_r;
  logic [WORD-1:0]   dest_r;
  logic              wb_r;
  logic [W_RD-1:0]   wb_rd_name_r;
  logic [W_DOPC-1:0] dopc_r;
  logic [W_OPC-1:0]  opc_r;
  logic [ADDR-1:0]   origaddr_r;
  logic [W_CC-1:0]   cc_r;
  logic [ADDR-1:0]   dm_addr_r;
  logic [CNT_W-1:0]  hazard_cnt_r;

  assign f_c           = extract_fields(INST_W'(bus.inst_i));
  assign bus.rd_name_o = W_RD'(f_c.rd);
  assign bus.rs_name_o = W_RD'(f_c.rs);

  idecode_fwd_sel #(.WORD(WORD), .W_RD(W_RD), .N_FWD(N_FWD)) u_sel_rd (
    .name     (W_RD'(f_c.rd)),
    .rf_data  (bus.rd_data_i),
    .reserved (bus.rd_reserved_i),
    .fwd_v    (bus.fwd_v_i),
    .fwd_name (bus.fwd_name_i),
    .fwd_data (bus.fwd_data_i),
    .data_c   (rd_val_c),
    .hazard_c (rd_hz_c)
  );

  idecode_fwd_sel #(.WORD(WORD), .W_RD(W_RD), .N_FWD(N_FWD)) u_sel_rs (
    .name     (W_RD'(f_c.rs)),
    .rf_data  (bus.rs_data_i),
    .reserved (bus.rs_reserved_i),
    .fwd_v    (bus.fwd_v_i),
    .fwd_name (bus.fwd_name_i),
    .fwd_data (bus.fwd_data_i),
    .data_c   (rs_val_c),
    .hazard_c (rs_hz_c)
  );

  // Hazard qualification and payload formation; an unresolved rs does not
  // matter when the immediate replaces it as source.
  always_comb begin
    hazard_c   = bus.v_i & (rd_hz_c | (~f_c.immf & rs_hz_c));
    v_c        = bus.v_i & ~hazard_c & ~bus.flush_i;
    wb_c       = wb_required(f_c.opc);
    imm_sext_c = {{(WORD-W_IMM){f_c.imm[W_IMM-1]}}, f_c.imm};
    src_c      = f_c.immf ? WORD'(expand_imm(f_c.opc, f_c.imm)) : rs_val_c;
    dm_addr_c  = ADDR'(rs_val_c + imm_sext_c);
  end

  // Reserve only on the cycle EX actually takes the instruction.
  assign bus.stall_o      = bus.v_i & ~bus.flush_i & (bus.stall_i | hazard_c);
  assign bus.rd_reserve_o = v_c & wb_c & ~bus.stall_i;

  // EX output register; flush kills the valid even while EX is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_r          <= 1'b0;
      src_r        <= '0;
      dest_r       <= '0;
      wb_r         <= 1'b0;
      wb_rd_name_r <= '0;
      dopc_r       <= '0;
      opc_r        <= '0;
      origaddr_r   <= '0;
      cc_r         <= '0;
      dm_addr_r    <= '0;
    end else begin
      if (bus.flush_i) begin
        v_r <= 1'b0;
      end else if (!bus.stall_i) begin
        v_r <= v_c;
      end
      if (!bus.stall_i) begin
        src_r        <= src_c;
        dest_r       <= rd_val_c;
        wb_r         <= wb_c;
        wb_rd_name_r <= W_RD'(f_c.rd);
        dopc_r       <= decode_ope(f_c.opc);
        opc_r        <= f_c.opc;
        origaddr_r   <= bus.origaddr_i;
        cc_r         <= f_c.cc;
        dm_addr_r    <= dm_addr_c;
      end
    end
  end

  // Saturating hazard-stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hazard_cnt_r <= '0;
    end else if (hazard_c && !bus.flush_i && (hazard_cnt_r != CNT_MAX)) begin
      hazard_cnt_r <= hazard_cnt_r + CNT_W'(1);
    end
  end

  assign bus.v_o          = v_r;
  assign bus.src_o        = src_r;
  assign bus.dest_o       = dest_r;
  assign bus.wb_o         = wb_r;
  assign bus.wb_rd_name_o = wb_rd_name_r;
  assign bus.dopc_o       = dopc_r;
  assign bus.opc_o        = opc_r;
  assign bus.origaddr_o   = origaddr_r;
  assign bus.cc_o         = cc_r;
  assign bus.dm_addr_o    = dm_addr_r;
  assign hazard_cnt_o     = hazard_cnt_r;

endmodule
